regfile_dump_streamer: RTL

- Hardware counterpart to the bench-side register printout: walks a contiguous range of register-file entries through a debug read port.
- Emits each (index, value) pair on a valid/ready stream toward a UART/log sink.
- Sits beside MIPS_Processor's register file; does not disturb the core's normal read/write ports.

---
 rtl/regfile_dump_streamer_if.sv | 27 ++
 rtl/regfile_dump_streamer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/regfile_dump_streamer_if.sv
// Bundle of the scan-control, debug-read and output-stream signals of
// regfile_dump_streamer. The streamer uses the slave view; the environment
// (the core side plus the log sink) uses the master view.
interface regfile_dump_streamer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  start, dbg_rdata, out_ready,
    output busy, done, dbg_addr, out_valid, out_index, out_data
  );

  modport master (
    output start, dbg_rdata, out_ready,
    input  busy, done, dbg_addr, out_valid, out_index, out_data
  );
endinterface

// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer: walks register-file entries FIRST_REG..LAST_REG
// through a debug read port and emits each (index, value) pair on a
// valid/ready stream. Every register costs two cycles (READ then SEND).
// A start is taken only while idle and not during the done cycle; the
// accepting edge raises busy, the next edge enters READ.
// Optional build macro REGDUMP_CHANGE_ONLY_EN: keep a shadow copy of each
// scanned register and skip beats whose value has not changed since it was
// last emitted. Skipped registers still take their two cycles.
module regfile_dump_streamer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 8,
  parameter int LAST_REG  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_dump_streamer_if.slave   bus
);

  if (FIRST_REG > LAST_REG) begin : g_bad_range
    $error("regfile_dump_streamer: FIRST_REG must not exceed LAST_REG");
  end
  if (LAST_REG >= (1 << ADDR_W)) begin : g_bad_width
    $error("regfile_dump_streamer: LAST_REG does not fit in ADDR_W bits");
  end

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic              skip;

`ifdef REGDUMP_CHANGE_ONLY_EN
  localparam int K = LAST_REG - FIRST_REG + 1;

  logic [DATA_W-1:0] shadow_q [K];
  logic [DATA_W-1:0] shadow_d [K];
  logic [K-1:0]      sh_vld_q, sh_vld_d;
  logic [ADDR_W-1:0] rd_slot, wr_slot;
  logic              beat_hs;

  assign rd_slot = dbg_addr_q - FIRST_A;
  assign wr_slot = out_index_q - FIRST_A;
  assign beat_hs = (state_q == SEND) && out_valid_q && bus.out_ready;
  // An unchanged value (already emitted once) is not sent again
  assign skip    = sh_vld_q[rd_slot] && (shadow_q[rd_slot] == bus.dbg_rdata);

  // Record the value of every beat the sink actually accepted
  always_comb begin
    shadow_d = shadow_q;
    sh_vld_d = sh_vld_q;
    if (beat_hs) begin
      shadow_d[wr_slot] = out_data_q;
      sh_vld_d[wr_slot] = 1'b1;
    end
  end

  // Valid bits are cleared by reset so the first scan emits everything
  always_ff @(posedge clk) begin
    if (reset) sh_vld_q <= '0;
    else       sh_vld_q <= sh_vld_d;
  end

  // Shadow data needs no reset; it is only trusted behind its valid bit
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end
`else
  assign skip = 1'b0;
`endif

  // Next-state and output logic of the scan FSM
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    dbg_addr_d  = dbg_addr_q;
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          state_d = READ;
        end else if (bus.start && !done_q) begin
          busy_d     = 1'b1;
          dbg_addr_d = FIRST_A;
        end
      end
      READ: begin
        out_index_d = dbg_addr_q;
        out_data_d  = bus.dbg_rdata;
        out_valid_d = !skip;
        state_d     = SEND;
      end
      SEND: begin
        // A skipped beat (valid low) advances as though it was accepted
        if (!out_valid_q || bus.out_ready) begin
          out_valid_d = 1'b0;
          if (dbg_addr_q == LAST_A) begin
            state_d = DONE;
          end else begin
            dbg_addr_d = dbg_addr_q + ADDR_W'(1);
            state_d    = READ;
          end
        end
      end
      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        dbg_addr_d = FIRST_A;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any scan in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      dbg_addr_q  <= FIRST_A;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      dbg_addr_q  <= dbg_addr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_addr  = dbg_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data  = out_data_q;

endmodule
